// File: rtl/rhx_session_sequencer.sv
// rhx_session_sequencer
//
// AXI4-Lite master that programs the RHD recording controller and the RHS
// stimulation controller with a fixed, timed write sequence, holds the
// session in RUN, and tears it down again with a two-write stop sequence.
//
// Ports:
//   aclk, aresetn          single clock, asynchronous active-low reset
//   start, stop            single-cycle control pulses from the PS
//   loopback               loopback select, latched at start
//   cfg_*                  register values, latched at start
//   busy, running, err     session status (err is sticky until next start)
//   m_axi_aw*/w*/b*        AXI4-Lite write channels (no read channels)
module rhx_session_sequencer #(
    parameter logic [31:0] RHD_BASE      = 32'h0000_0000,
    parameter logic [31:0] RHS_BASE      = 32'h0001_0000,
    parameter logic [31:0] INIT_WAIT_CYC = 32'd28000,
    parameter logic [31:0] MAG_WAIT_CYC  = 32'd5600,
    parameter logic [31:0] GAP_WAIT_CYC  = 32'd560,
    parameter logic [31:0] ARM_WAIT_CYC  = 32'd28000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        stop,
    input  logic        loopback,
    input  logic [31:0] cfg_rhd_delay,
    input  logic [31:0] cfg_rhs_mag,
    input  logic [31:0] cfg_rhs_zcheck,
    input  logic [31:0] cfg_rhs_chan,
    input  logic [31:0] cfg_rhs_pw,
    input  logic [31:0] cfg_rhs_ipd,
    input  logic [31:0] cfg_rhs_npulse,
    input  logic [31:0] cfg_rhd_pktlen,
    input  logic [31:0] cfg_rhs_pktlen,
    output logic        busy,
    output logic        running,
    output logic        err,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    // The stop sequence reuses ADDR/RESP; stop_seq_q marks that phase.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RESP,
        S_WAIT,
        S_RUN
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'd14;

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [31:0] cnt_q, cnt_d;
    logic        stop_seq_q, stop_seq_d;
    logic        stop_idx_q, stop_idx_d;
    logic        stop_pend_q, stop_pend_d;
    logic        lb_q, lb_d;
    logic        err_q, err_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cfg_q [9];
    logic [31:0] cfg_d [9];

    logic        do_issue;
    logic        go_stop;
    logic [31:0] iss_addr;
    logic [31:0] iss_data;
    logic        aw_done;
    logic        w_done;
    logic        bad_resp;
    logic [3:0]  nxt;
    logic [31:0] nxt_word;

    // Register address for each configuration step.
    function automatic logic [31:0] step_addr(input logic [3:0] idx);
        logic [31:0] a;
        case (idx)
            4'd0:    a = RHD_BASE + 32'h04;
            4'd1:    a = RHD_BASE + 32'h08;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8:
                     a = RHS_BASE + {26'd0, idx - 4'd1, 2'b00};
            4'd14:   a = RHD_BASE;
            default: a = RHS_BASE;
        endcase
        return a;
    endfunction

    // Hold time after a step's B handshake; zero for untimed steps.
    function automatic logic [31:0] step_wait(input logic [3:0] idx);
        logic [31:0] w;
        case (idx)
            4'd9:        w = INIT_WAIT_CYC;
            4'd10, 4'd12: w = GAP_WAIT_CYC;
            4'd11:       w = MAG_WAIT_CYC;
            4'd13:       w = ARM_WAIT_CYC;
            default:     w = 32'd0;
        endcase
        return w;
    endfunction

    assign nxt = step_q + 4'd1;

    // Data word for the step following the current one.
    always_comb begin
        nxt_word = 32'd0;
        if (nxt <= 4'd8) begin
            nxt_word = cfg_q[nxt];
        end else begin
            case (nxt)
                4'd9:    nxt_word = {26'd0, lb_q, 5'h03};
                4'd11:   nxt_word = {26'd0, lb_q, 5'h05};
                4'd13:   nxt_word = {26'd0, lb_q, 5'h09};
                4'd14:   nxt_word = {27'd0, lb_q, 4'h5};
                default: nxt_word = 32'd0;
            endcase
        end
    end

    // A channel counts as done once its handshake has happened or happens now.
    assign aw_done  = !awvalid_q || m_axi_awready;
    assign w_done   = !wvalid_q || m_axi_wready;
    assign bad_resp = (m_axi_bresp != 2'b00);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        stop_seq_d  = stop_seq_q;
        stop_idx_d  = stop_idx_q;
        stop_pend_d = stop_pend_q;
        lb_d        = lb_q;
        err_d       = err_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        cfg_d       = cfg_q;
        do_issue    = 1'b0;
        go_stop     = 1'b0;
        iss_addr    = 32'd0;
        iss_data    = 32'd0;

        case (state_q)
            S_IDLE: begin
                // start has priority; a coincident stop is simply dropped
                if (start) begin
                    err_d       = 1'b0;
                    lb_d        = loopback;
                    cfg_d[0]    = cfg_rhd_delay;
                    cfg_d[1]    = cfg_rhd_pktlen;
                    cfg_d[2]    = cfg_rhs_mag;
                    cfg_d[3]    = cfg_rhs_pktlen;
                    cfg_d[4]    = cfg_rhs_zcheck;
                    cfg_d[5]    = cfg_rhs_chan;
                    cfg_d[6]    = cfg_rhs_pw;
                    cfg_d[7]    = cfg_rhs_ipd;
                    cfg_d[8]    = cfg_rhs_npulse;
                    step_d      = 4'd0;
                    stop_seq_d  = 1'b0;
                    stop_idx_d  = 1'b0;
                    stop_pend_d = 1'b0;
                    do_issue    = 1'b1;
                    iss_addr    = step_addr(4'd0);
                    iss_data    = cfg_rhd_delay;
                end
            end

            S_ADDR: begin
                if (stop && !stop_seq_q) stop_pend_d = 1'b1;
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = S_RESP;
                    bready_d = 1'b1;
                end
            end

            S_RESP: begin
                if (stop && !stop_seq_q) stop_pend_d = 1'b1;
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    if (stop_seq_q) begin
                        // errors during teardown are flagged but never stall it
                        if (bad_resp) err_d = 1'b1;
                        if (!stop_idx_q) begin
                            stop_idx_d = 1'b1;
                            do_issue   = 1'b1;
                            iss_addr   = RHD_BASE;
                            iss_data   = 32'd0;
                        end else begin
                            state_d    = S_IDLE;
                            stop_seq_d = 1'b0;
                            stop_idx_d = 1'b0;
                        end
                    end else if (bad_resp) begin
                        err_d   = 1'b1;
                        go_stop = 1'b1;
                    end else if (stop_pend_q || stop) begin
                        go_stop = 1'b1;
                    end else if (step_q == LAST_STEP) begin
                        state_d = S_RUN;
                    end else if (step_wait(step_q) != 32'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = step_wait(step_q) - 32'd1;
                    end else begin
                        step_d   = nxt;
                        do_issue = 1'b1;
                        iss_addr = step_addr(nxt);
                        iss_data = nxt_word;
                    end
                end
            end

            S_WAIT: begin
                if (stop || stop_pend_q) begin
                    go_stop = 1'b1;
                end else if (cnt_q == 32'd0) begin
                    step_d   = nxt;
                    do_issue = 1'b1;
                    iss_addr = step_addr(nxt);
                    iss_data = nxt_word;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end

            S_RUN: begin
                if (stop) go_stop = 1'b1;
            end

            default: state_d = S_IDLE;
        endcase

        // Stop sequence begins by clearing the RHS control register.
        if (go_stop) begin
            stop_seq_d  = 1'b1;
            stop_idx_d  = 1'b0;
            stop_pend_d = 1'b0;
            do_issue    = 1'b1;
            iss_addr    = RHS_BASE;
            iss_data    = 32'd0;
        end

        if (do_issue) begin
            state_d   = S_ADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = iss_addr;
            wdata_d   = iss_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            step_q      <= 4'd0;
            cnt_q       <= 32'd0;
            stop_seq_q  <= 1'b0;
            stop_idx_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            lb_q        <= 1'b0;
            err_q       <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            awaddr_q    <= 32'd0;
            wdata_q     <= 32'd0;
            for (int i = 0; i < 9; i++) cfg_q[i] <= 32'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            stop_seq_q  <= stop_seq_d;
            stop_idx_q  <= stop_idx_d;
            stop_pend_q <= stop_pend_d;
            lb_q        <= lb_d;
            err_q       <= err_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            for (int i = 0; i < 9; i++) cfg_q[i] <= cfg_d[i];
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign running       = (state_q == S_RUN);
    assign err           = err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: doc/rhx_session_sequencer.md
# rhx_session_sequencer

AXI4-Lite master that autonomously configures the RHD recording controller and the RHS stimulation controller and starts and stops a recording/stimulation session. It replaces the host-driven register programming sequence with a fixed, timed hardware sequence. It sits between the PS control registers (cfg inputs, start/stop) and the AXI-Lite interconnect feeding both controllers.

## Interface
- RHD_BASE, 32'h0000_0000, base address of RHD controller register space
- RHS_BASE, 32'h0001_0000, base address of RHS controller register space
- INIT_WAIT_CYC, 28000, cycles held in RHS init (ctrl=0x03) before clearing
- MAG_WAIT_CYC, 5600, cycles held in RHS magnitude-set (ctrl=0x05) before clearing
- GAP_WAIT_CYC, 560, idle cycles after each RHS ctrl clear
- ARM_WAIT_CYC, 28000, cycles between RHS stim enable and RHD acquisition start
- aclk in 1 — single clock for all logic and the AXI port
- aresetn in 1 — asynchronous, active-low reset
- start in 1 — single-cycle pulse; begin session (ignored unless IDLE)
- stop in 1 — single-cycle pulse; end session or abort configuration
- loopback in 1 — sampled at start; selects loopback modes
- cfg_rhd_delay, cfg_rhs_mag, cfg_rhs_zcheck, cfg_rhs_chan, cfg_rhs_pw, cfg_rhs_ipd, cfg_rhs_npulse in 32 each — register values, latched at start
- cfg_rhd_pktlen, cfg_rhs_pktlen in 32 each — packet-length register values, latched at start
- busy out 1 — high in any state except IDLE
- running out 1 — high only in RUN
- err out 1 — sticky; set on non-OKAY BRESP, cleared at next accepted start
- m_axi_awaddr out 32, m_axi_awprot out 3 (always 0), m_axi_awvalid out 1, m_axi_awready in 1
- m_axi_wdata out 32, m_axi_wstrb out 4 (always 4'hF), m_axi_wvalid out 1, m_axi_wready in 1
- m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1

## Operation
- Write steps, in order (offset from base, data):
  - 0: RHD+0x04 cfg_rhd_delay
  - 1: RHD+0x08 cfg_rhd_pktlen
  - 2: RHS+0x04 cfg_rhs_mag
  - 3: RHS+0x08 cfg_rhs_pktlen
  - 4: RHS+0x0C cfg_rhs_zcheck
  - 5: RHS+0x10 cfg_rhs_chan
  - 6: RHS+0x14 cfg_rhs_pw
  - 7: RHS+0x18 cfg_rhs_ipd
  - 8: RHS+0x1C cfg_rhs_npulse
  - 9: RHS+0x00 0x03|lb<<5, then WAIT INIT_WAIT_CYC
  - 10: RHS+0x00 0, then WAIT GAP_WAIT_CYC
  - 11: RHS+0x00 0x05|lb<<5, then WAIT MAG_WAIT_CYC
  - 12: RHS+0x00 0, then WAIT GAP_WAIT_CYC
  - 13: RHS+0x00 0x09|lb<<5, then WAIT ARM_WAIT_CYC
  - 14: RHD+0x00 0x05|lb<<4, then enter RUN
  - lb is the loopback value latched at start.
- Stop sequence: RHS+0x00 ← 0, then RHD+0x00 ← 0, then IDLE.
- FSM states: IDLE → ADDR (AW/W outstanding) → RESP (waiting for B) → WAIT (timed steps only) → next step … → RUN → STOPW (stop sequence, reusing ADDR/RESP) → IDLE.
- stop in RUN: enter the stop sequence.
- stop during steps 0–14: finish the current AXI transaction (never abandon a started handshake), then enter the stop sequence. A pending stop in WAIT aborts the wait immediately.
- stop while a stop is already pending or in STOPW/IDLE: ignored. stop and start in the same cycle in IDLE: start wins, stop is dropped.
- Non-OKAY BRESP during steps 0–14: set err, enter the stop sequence. Non-OKAY BRESP during the stop sequence: set err and continue to the next stop write.

## Timing
- Reset values: all outputs 0; state IDLE; step index 0.
- awvalid and wvalid rise together the cycle after the trigger (start accepted, previous B accepted, or WAIT expired).
- Each of awvalid/wvalid is held, with stable addr/data, until its own ready is seen, then drops independently.
- bready rises the cycle after both AW and W have been accepted and stays high until bvalid is seen.
- WAIT lasts exactly N cycles, counted from the cycle after the B handshake; the next awvalid follows in the cycle after that.
- running rises the cycle after the step-14 B handshake and falls the cycle after a stop is accepted.
- busy rises the cycle after start and falls the cycle after the final stop B handshake.
- Wait counter is 32-bit; N=0 means zero WAIT cycles.
- aresetn asserted mid-transaction drops all valid/ready outputs asynchronously. The slave side is reset by the same aresetn.

## Test plan
- Nominal session, INIT=20, MAG=8, GAP=4, ARM=10, loopback=1, always-ready slave → exactly 15 writes in step order with ctrl data 0x23, 0, 0x25, 0, 0x29, RHD 0x15; running=1; measured gaps of 20/4/8/4/10 cycles.
- stop in RUN → RHS+0x00←0 then RHD+0x00←0; running falls the next cycle; busy falls after the second B handshake; err=0.
- Slave with awready delayed 3 cycles and wready delayed 1 → addr/data held stable until accepted; a single B handshake per write; no step skipped.
- SLVERR on step 5 → err=1; stop sequence runs with no writes from step 6 onward; IDLE; next start clears err.
- stop pulsed during the step-9 WAIT (cycle 5 of 20) → wait aborted; stop sequence runs within 1 cycle; RHD ctrl never written with 0x05.
- aresetn pulled low while awvalid=1 → all outputs 0 immediately; after release, start replays the sequence from step 0.
